pito_apb_csr_slave: RTL and testbench
=====================================

PITO_APB_CSR_SLAVE -- requirements
Module: pito_apb_csr_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default pito_pkg::APB_ADDR_WIDTH, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default pito_pkg::APB_DATA_WIDTH, APB data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; the last register is a read-only status register.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, number of pready-low access cycles; range 0..15.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 psel  in  1  APB select.
REQ-008 penable  in  1  APB enable.
REQ-009 pwrite  in  1  1 = write, 0 = read.
REQ-010 paddr  in  ADDR_WIDTH  byte address.
REQ-011 pwdata  in  DATA_WIDTH  write data.
REQ-012 pstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-013 prdata  out  DATA_WIDTH  read data.
REQ-014 pready  out  1  transfer complete.
REQ-015 pslverr  out  1  transfer error.
REQ-016 csr_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*32+:32].
REQ-017 csr_wr  out  NUM_REGS  one-cycle pulse per committed register write.
REQ-018 status_i  in  DATA_WIDTH  value returned when reading register NUM_REGS-1.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-020 IDLE SHALL move to ACCESS on psel&!penable when WAIT_CYCLES>0, and directly to RESP when WAIT_CYCLES=0; the wait counter SHALL load WAIT_CYCLES on this transition.
REQ-021 In ACCESS the counter SHALL decrement each cycle, and the FSM SHALL move to RESP when the counter reaches 1.
REQ-022 pready SHALL be registered and high only in RESP, for exactly one cycle; RESP SHALL always return to IDLE.
REQ-023 With the setup phase at cycle S, pready SHALL be high at cycle S+1+WAIT_CYCLES.
REQ-024 The register index SHALL be paddr[ADDR_WIDTH-1:2], captured at the setup cycle.
REQ-025 pslverr SHALL be high only together with pready, in any of these cases: paddr[1:0]!=0; index>=NUM_REGS; write to index NUM_REGS-1.
REQ-026 A write SHALL commit at the end of the RESP cycle, only if pslverr=0.
REQ-027 On commit, each byte b of the register SHALL update from pwdata only where pstrb[b]=1.
REQ-028 On commit, csr_wr[index] SHALL pulse in the cycle after RESP.
REQ-029 A write with pstrb=0 SHALL commit nothing but SHALL still pulse csr_wr.
REQ-030 prdata SHALL be registered and valid in RESP: register contents for indices <NUM_REGS-1, status_i sampled at the setup cycle for index NUM_REGS-1, and 0 on error.
REQ-031 prdata SHALL be 0 whenever pready=0.
REQ-032 If psel drops in ACCESS or RESP, the FSM SHALL return to IDLE next cycle, with no commit and no csr_wr pulse.
REQ-033 penable=1 seen while in IDLE without a prior setup SHALL be ignored.
REQ-034 Back-to-back transfers SHALL be accepted: a setup in the cycle after RESP starts a new transfer.

Reset
REQ-035 rst SHALL force state IDLE, counter 0, all registers 0, and pready, pslverr, prdata and csr_wr to 0 on the next edge.
REQ-036 rst asserted mid-transfer SHALL abort the transfer with no commit; pready SHALL stay low until a new setup phase.

Structure
REQ-037 The FSM state enum and register index constants (CSR_STATUS_IDX = NUM_REGS-1) SHALL reside in pito_pkg.
REQ-038 One sub-module, pito_csr_bank (the byte-strobed register array with write pulses), SHALL be instantiated; the FSM SHALL stay in the top module.

Verification
REQ-039 Reset then write paddr=0x4, pwdata=0xDEADBEEF, pstrb=0xF, WAIT_CYCLES=1 -> pready at S+2, pslverr=0, csr_q[63:32]=0xDEADBEEF, csr_wr=8'h02 one cycle.
REQ-040 Write paddr=0x4, pwdata=0x11223344, pstrb=0x5 over 0xDEADBEEF -> register reads back 0xDE22BE44.
REQ-041 Read paddr=0x1C with status_i=0xA5A5A5A5 -> prdata=0xA5A5A5A5, pslverr=0; write to the same address -> pslverr=1, no csr_wr pulse.
REQ-042 Access paddr=0x22 (misaligned) and paddr=0x20 (out of range) -> pslverr=1, prdata=0, registers unchanged.
REQ-043 Start a write, assert rst during ACCESS -> no commit, pready=0, csr_q all 0; the following read of 0x0 returns 0.
REQ-044 WAIT_CYCLES=0 build: back-to-back write/read of 0x8 with 0x0000CAFE -> each pready at S+1, read returns 0x0000CAFE.

Source files
------------

// File: rtl/pito_pkg.sv
// Shared types and constants for the pito APB CSR slave and its register bank.
package pito_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int CSR_NUM_REGS   = 8;
  localparam int CSR_STATUS_IDX = CSR_NUM_REGS - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } apb_state_e;

  // The last register of any bank size is the read-only status slot.
  function automatic int csr_status_idx(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/pito_apb_csr_slave_if.sv
// APB bus bundle between a master and the pito CSR slave.
interface pito_apb_csr_slave_if #(
  parameter int ADDR_WIDTH = pito_pkg::APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = pito_pkg::APB_DATA_WIDTH
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/pito_csr_bank.sv
// Byte-strobed register array; each committed write raises a one-cycle pulse.
module pito_csr_bank
  import pito_pkg::*;
#(
  parameter int NUM_REGS   = CSR_NUM_REGS,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int IW         = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_we,
  input  logic [IW-1:0]                  i_idx,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_strb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_csr_q,
  output logic [NUM_REGS-1:0]            o_csr_wr
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_csr_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_csr_wr <= '0;
    end else begin
      r_csr_wr <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_we && (i_idx == IW'(i))) begin
          r_csr_wr[i] <= 1'b1;
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_strb[b]) r_regs[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_csr_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign o_csr_wr = r_csr_wr;

endmodule

// File: rtl/pito_apb_csr_slave.sv
// APB CSR slave: fixed-latency access FSM in front of a byte-strobed register bank.
module pito_apb_csr_slave
  import pito_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int NUM_REGS    = CSR_NUM_REGS,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  pito_apb_csr_slave_if.slave            apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] csr_q,
  output logic [NUM_REGS-1:0]            csr_wr,
  input  logic [DATA_WIDTH-1:0]          status_i
);

  localparam int          IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int          STATUS_IDX = csr_status_idx(NUM_REGS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  apb_state_e              r_state;
  logic [3:0]              r_cnt;
  logic [IW-1:0]           r_idx;
  logic                    r_err;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic [DATA_WIDTH-1:0]   r_status;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [DATA_WIDTH-1:0]   r_prdata;

  logic [ADDR_WIDTH-3:0]   w_word;
  logic                    w_setup;
  logic                    w_setup_err;
  logic [IW-1:0]           w_setup_idx;
  logic [IW-1:0]           w_resp_idx;
  logic                    w_resp_err;
  logic                    w_resp_write;
  logic [DATA_WIDTH-1:0]   w_resp_status;
  logic [DATA_WIDTH-1:0]   w_reg_sel;
  logic [DATA_WIDTH-1:0]   w_resp_rdata;
  logic                    w_commit;

  assign w_word      = apb.paddr[ADDR_WIDTH-1:2];
  assign w_setup     = apb.psel & ~apb.penable;
  assign w_setup_idx = apb.paddr[2 +: IW];
  assign w_setup_err = (apb.paddr[1:0] != 2'b00)
                    || (w_word >= (ADDR_WIDTH-2)'(NUM_REGS))
                    || (apb.pwrite && (w_word == (ADDR_WIDTH-2)'(STATUS_IDX)));

  // Zero-wait transfers build the response straight from the setup-cycle bus values.
  assign w_resp_idx    = (r_state == IDLE) ? w_setup_idx : r_idx;
  assign w_resp_err    = (r_state == IDLE) ? w_setup_err : r_err;
  assign w_resp_write  = (r_state == IDLE) ? apb.pwrite  : r_write;
  assign w_resp_status = (r_state == IDLE) ? status_i    : r_status;

  always_comb begin
    w_reg_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_resp_idx == IW'(i)) w_reg_sel = csr_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_resp_rdata = (w_resp_err || w_resp_write)         ? '0 :
                        (w_resp_idx == IW'(STATUS_IDX))       ? w_resp_status :
                                                                w_reg_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_status  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_idx    <= w_setup_idx;
            r_err    <= w_setup_err;
            r_write  <= apb.pwrite;
            r_wdata  <= apb.pwdata;
            r_strb   <= apb.pstrb;
            r_status <= status_i;
            r_cnt    <= WAIT_LOAD;
            if (WAIT_CYCLES == 0) begin
              r_state   <= RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_resp_err;
              r_prdata  <= w_resp_rdata;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!apb.psel) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state   <= RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_resp_err;
              r_prdata  <= w_resp_rdata;
            end
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A master that abandons the transfer during the response phase gets no commit.
  assign w_commit = (r_state == RESP) && apb.psel && r_write && !r_err;

  pito_csr_bank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IW         (IW)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_commit),
    .i_idx    (r_idx),
    .i_wdata  (r_wdata),
    .i_strb   (r_strb),
    .o_csr_q  (csr_q),
    .o_csr_wr (csr_wr)
  );

  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign apb.prdata  = r_prdata;

endmodule

// File: tb/tb_pito_apb_csr_slave.sv
// Bench for pito_apb_csr_slave: vector table with scoreboard on a WAIT_CYCLES=1 build, plus a zero-wait build.
module tb_pito_apb_csr_slave;
  import pito_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_b;
  logic [DW-1:0]     status_a, status_b;
  logic [NR*DW-1:0]  csr_q_a, csr_q_b;
  logic [NR-1:0]     csr_wr_a, csr_wr_b;

  pito_apb_csr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_a ();
  pito_apb_csr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_b ();

  pito_apb_csr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a), .apb(apb_a), .csr_q(csr_q_a), .csr_wr(csr_wr_a), .status_i(status_a)
  );

  pito_apb_csr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .apb(apb_b), .csr_q(csr_q_b), .csr_wr(csr_wr_b), .status_i(status_b)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] status;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  wr_pulse;
    logic        is_read;
    int          lat;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [NR];
  exp_t        sb [$];
  vec_t        vecs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t predict(input vec_t v);
    exp_t e;
    int   idx;
    idx       = int'(v.addr[4:2]);
    e.err     = (v.addr[1:0] != 2'b00) || (v.addr[31:2] >= NR) || (v.wr && v.addr[31:2] == NR - 1);
    e.is_read = !v.wr;
    e.lat     = 2;
    e.rdata   = 32'h0;
    if (!v.wr && !e.err) e.rdata = (idx == NR - 1) ? v.status : model[idx];
    e.wr_pulse = (v.wr && !e.err) ? (8'h01 << idx) : 8'h00;
    return e;
  endfunction

  task automatic check_bank_a(input string name);
    for (int i = 0; i < NR; i++) chk(name, csr_q_a[i*DW +: DW], model[i]);
  endtask

  task automatic run_a(input vec_t v);
    exp_t e;
    int   lat;
    bit   seen;
    @(posedge clk); #1;
    status_a      = v.status;
    apb_a.psel    = 1'b1;
    apb_a.penable = 1'b0;
    apb_a.pwrite  = v.wr;
    apb_a.paddr   = v.addr;
    apb_a.pwdata  = v.wdata;
    apb_a.pstrb   = v.strb;
    sb.push_back(predict(v));
    @(posedge clk); #1;
    apb_a.penable = 1'b1;
    status_a      = ~v.status;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (apb_a.pready) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        chk("prdata_while_not_ready", apb_a.prdata, 32'h0);
      end
    end
    e = sb.pop_front();
    if (!seen) chk("pready_timeout", 1'b0, 1'b1);
    else begin
      chk("pready_latency", lat, e.lat);
      chk("pslverr", apb_a.pslverr, e.err);
      if (e.is_read) chk("prdata", apb_a.prdata, e.rdata);
    end
    @(posedge clk); #1;
    apb_a.psel    = 1'b0;
    apb_a.penable = 1'b0;
    @(negedge clk);
    chk("pready_one_cycle", apb_a.pready, 1'b0);
    chk("csr_wr", csr_wr_a, e.wr_pulse);
    if (e.wr_pulse != 8'h00) begin
      for (int b = 0; b < 4; b++)
        if (v.strb[b]) model[v.addr[4:2]][b*8 +: 8] = v.wdata[b*8 +: 8];
    end
    check_bank_a("csr_q");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apb_a.psel = 0; apb_a.penable = 0; apb_a.pwrite = 0; apb_a.paddr = 0; apb_a.pwdata = 0; apb_a.pstrb = 0;
    apb_b.psel = 0; apb_b.penable = 0; apb_b.pwrite = 0; apb_b.paddr = 0; apb_b.pwdata = 0; apb_b.pstrb = 0;
    status_a = 32'h0; status_b = 32'h0;
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    vecs.push_back('{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h04, 32'h11223344, 4'h5, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 32'h0,        4'h0, 32'hA5A5A5A5});
    vecs.push_back('{1'b1, 32'h1C, 32'h12345678, 4'hF, 32'hA5A5A5A5});
    vecs.push_back('{1'b0, 32'h22, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 32'h08, 32'h99999999, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h00, 32'hCAFEF00D, 4'hC, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h18, 32'h0,        4'h0, 32'h0});

    repeat (3) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("reset_pready", apb_a.pready, 1'b0);
    chk("reset_pslverr", apb_a.pslverr, 1'b0);
    chk("reset_prdata", apb_a.prdata, 32'h0);
    chk("reset_csr_wr", csr_wr_a, 8'h00);
    chk("reset_csr_q_b_zero", (csr_q_b == '0), 1'b1);
    check_bank_a("reset_csr_q");

    foreach (vecs[i]) run_a(vecs[i]);
    chk("rmw_strobe_value", model[1], 32'hDE22BE44);

    // penable without a setup phase in IDLE
    @(posedge clk); #1;
    apb_a.psel = 1'b1; apb_a.penable = 1'b1; apb_a.pwrite = 1'b1;
    apb_a.paddr = 32'h0; apb_a.pwdata = 32'hFFFFFFFF; apb_a.pstrb = 4'hF;
    repeat (4) begin
      @(negedge clk);
      chk("orphan_enable_pready", apb_a.pready, 1'b0);
      chk("orphan_enable_csr_wr", csr_wr_a, 8'h00);
    end
    @(posedge clk); #1; apb_a.psel = 1'b0; apb_a.penable = 1'b0;
    check_bank_a("orphan_enable_csr_q");

    // psel dropped during ACCESS
    @(posedge clk); #1;
    apb_a.psel = 1'b1; apb_a.penable = 1'b0; apb_a.pwrite = 1'b1;
    apb_a.paddr = 32'h0C; apb_a.pwdata = 32'h55555555; apb_a.pstrb = 4'hF;
    @(posedge clk); #1; apb_a.psel = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_pready", apb_a.pready, 1'b0);
      chk("abort_csr_wr", csr_wr_a, 8'h00);
    end
    check_bank_a("abort_csr_q");

    // reset during ACCESS
    @(posedge clk); #1;
    apb_a.psel = 1'b1; apb_a.penable = 1'b0; apb_a.pwrite = 1'b1;
    apb_a.paddr = 32'h00; apb_a.pwdata = 32'h77777777; apb_a.pstrb = 4'hF;
    @(posedge clk); #1; apb_a.penable = 1'b1; rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0; apb_a.psel = 1'b0; apb_a.penable = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_abort_pready", apb_a.pready, 1'b0);
      chk("rst_abort_csr_wr", csr_wr_a, 8'h00);
    end
    chk("rst_abort_csr_q_zero", (csr_q_a == '0), 1'b1);
    run_a('{1'b0, 32'h00, 32'h0, 4'h0, 32'h0});

    // zero-wait build: back-to-back write then read
    @(posedge clk); #1;
    apb_b.psel = 1'b1; apb_b.penable = 1'b0; apb_b.pwrite = 1'b1;
    apb_b.paddr = 32'h08; apb_b.pwdata = 32'h0000CAFE; apb_b.pstrb = 4'hF;
    @(posedge clk); #1; apb_b.penable = 1'b1;
    @(negedge clk);
    chk("w0_write_pready", apb_b.pready, 1'b1);
    chk("w0_write_pslverr", apb_b.pslverr, 1'b0);
    @(posedge clk); #1;
    apb_b.penable = 1'b0; apb_b.pwrite = 1'b0; apb_b.pwdata = 32'h0;
    @(negedge clk);
    chk("w0_csr_wr", csr_wr_b, 8'h04);
    chk("w0_gap_pready", apb_b.pready, 1'b0);
    chk("w0_csr_q", csr_q_b[95:64], 32'h0000CAFE);
    @(posedge clk); #1; apb_b.penable = 1'b1;
    @(negedge clk);
    chk("w0_read_pready", apb_b.pready, 1'b1);
    chk("w0_read_prdata", apb_b.prdata, 32'h0000CAFE);
    chk("w0_read_pslverr", apb_b.pslverr, 1'b0);
    @(posedge clk); #1; apb_b.psel = 1'b0; apb_b.penable = 1'b0;
    @(negedge clk);
    chk("w0_read_no_wr", csr_wr_b, 8'h00);
    chk("w0_read_prdata_low", apb_b.prdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
